// File: rtl/mem_stage.sv
// Data-memory access stage: issues a req/ack transaction to a variable-latency
// data memory, stalls the core until it completes, and picks the writeback value.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic        hlt,
    input  logic [15:0] alu_res,
    input  logic [15:0] st_data,
    input  logic        rf_we_in,
    output logic        stall,
    output logic [15:0] wb_data,
    output logic        rf_we,
    output logic        err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [15:0] dm_addr,
    output logic [15:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [15:0] dm_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ld_q, ld_d;
    logic        err_q, err_d;
    logic        access;

    assign access = (mem_re | mem_we) & ~hlt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    addr_d  = alu_res;
                    wdata_d = st_data;
                    we_d    = mem_we;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack arriving on the final counted cycle still wins over the timeout.
                if (dm_ack) begin
                    if (!we_q) ld_d = dm_rdata;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    ld_d    = 16'h0000;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            ld_q    <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    assign stall     = ((state_q == S_IDLE) && access) || (state_q == S_WAIT);
    assign rf_we     = rf_we_in & ~stall;
    assign wb_data   = ((state_q == S_DONE) && !we_q) ? ld_q : alu_res;
    assign err       = err_q;
    assign dm_req    = req_q;
    assign dm_we     = we_q;
    assign dm_addr   = addr_q;
    assign dm_wdata  = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, timeout, reset mid-access,
// back-to-back and dual requests, with writeback values checked via a queue.
module tb_mem_stage;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re, mem_we, hlt, rf_we_in;
    logic [15:0] alu_res, st_data;
    logic        stall, rf_we, err, dm_req, dm_we;
    logic [15:0] wb_data, dm_addr, dm_wdata;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .hlt(hlt),
        .alu_res(alu_res), .st_data(st_data), .rf_we_in(rf_we_in),
        .stall(stall), .wb_data(wb_data), .rf_we(rf_we), .err(err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One memory instruction: present in cycle T, ack in T+k (k=0: never).
    task automatic run_access(input logic re, input logic we, input logic [15:0] addr,
                              input logic [15:0] sd, input logic rfwe, input int k,
                              input logic [15:0] rdata, input int exp_wait,
                              input logic exp_err, input logic hlt_wait);
        int  waits;
        bit  done;
        logic [15:0] exp_wb;
        @(negedge clk);
        mem_re = re; mem_we = we; alu_res = addr; st_data = sd;
        rf_we_in = rfwe; dm_ack = 1'b0; hlt = 1'b0;
        #1;
        chk("start_state", dbg_state, ST_IDLE);
        chk("start_stall", stall, 1'b1);
        chk("start_rf_we", rf_we, 1'b0);
        exp_q.push_back(we ? addr : (k == 0 ? 16'h0000 : rdata));
        waits = 0;
        done  = 0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            hlt      = hlt_wait;
            dm_ack   = (i == k);
            dm_rdata = (i == k) ? rdata : 16'($urandom_range(0, 65535));
            #1;
            if (dbg_state == ST_DONE) begin
                done = 1;
            end else begin
                waits++;
                chk("wait_state", dbg_state, ST_WAIT);
                chk("wait_req", dm_req, 1'b1);
                chk("wait_stall", stall, 1'b1);
                chk("wait_addr", dm_addr, addr);
                chk("wait_we", dm_we, we);
                if (we) chk("wait_wdata", dm_wdata, sd);
            end
        end
        dm_ack = 1'b0;
        if (!done) begin
            chk("done_reached", 1'b0, 1'b1);
            void'(exp_q.pop_back());
        end else begin
            chk("wait_cycles", waits, exp_wait);
            chk("done_stall", stall, 1'b0);
            chk("done_rf_we", rf_we, rfwe);
            chk("done_req", dm_req, 1'b0);
            chk("done_err", err, exp_err);
            if (exp_q.size() == 0) begin
                chk("exp_q_nonempty", 1'b0, 1'b1);
            end else begin
                exp_wb = exp_q.pop_front();
                chk("done_wb", wb_data, exp_wb);
            end
        end
    endtask

    initial begin
        rst = 1'b1; mem_re = 1'b0; mem_we = 1'b0; hlt = 1'b0; rf_we_in = 1'b0;
        alu_res = 16'h5555; st_data = 16'h0000; dm_ack = 1'b0; dm_rdata = 16'h0000;

        // Reset held for two cycles.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req", dm_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wb", wb_data, 16'h5555);
        chk("rst_addr", dm_addr, 16'h0000);
        chk("rst_state", dbg_state, ST_IDLE);

        // Non-memory instruction: single cycle, no stall.
        @(negedge clk);
        alu_res = 16'($urandom_range(0, 65535));
        rf_we_in = 1'b1;
        #1;
        chk("alu_stall", stall, 1'b0);
        chk("alu_rf_we", rf_we, 1'b1);
        chk("alu_wb", wb_data, alu_res);

        // Halt blocks a new access.
        @(negedge clk);
        mem_re = 1'b1; hlt = 1'b1;
        #1;
        chk("hlt_stall", stall, 1'b0);
        @(negedge clk);
        #1;
        chk("hlt_state", dbg_state, ST_IDLE);
        chk("hlt_req", dm_req, 1'b0);

        // Load, ack after three wait cycles.
        run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 3, 16'hBEEF, 3, 1'b0, 1'b0);
        // Store, immediate ack.
        run_access(1'b0, 1'b1, 16'h1234, 16'h00A5, 1'b0, 1, 16'h7777, 1, 1'b0, 1'b0);
        // Back-to-back load, store, then dual request (halt raised mid-wait).
        run_access(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 2, 16'h1357, 2, 1'b0, 1'b0);
        run_access(1'b0, 1'b1, 16'h0102, 16'hCAFE, 1'b0, 1, 16'h0000, 1, 1'b0, 1'b0);
        run_access(1'b1, 1'b1, 16'h0104, 16'h4242, 1'b1, 2, 16'h9999, 2, 1'b0, 1'b1);
        @(negedge clk);
        hlt = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        #1;
        chk("post_dual_state", dbg_state, ST_IDLE);

        // Timeout: dm_req high TIMEOUT+1 cycles, then a good load with err sticky.
        run_access(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 0, 16'h0000, 5, 1'b1, 1'b0);
        run_access(1'b1, 1'b0, 16'h0204, 16'h0000, 1'b1, 1, 16'h2468, 1, 1'b1, 1'b0);

        // Reset during WAIT; a late ack must be ignored.
        @(negedge clk);
        mem_re = 1'b1; mem_we = 1'b0; alu_res = 16'h0080; rf_we_in = 1'b0;
        #1;
        chk("rw_start_stall", stall, 1'b1);
        @(negedge clk);
        mem_re = 1'b0;
        #1;
        chk("rw_req1", dm_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_req2", dm_req, 1'b1);
        @(negedge clk);
        rst = 1'b0; dm_ack = 1'b1; dm_rdata = 16'hDEAD;
        #1;
        chk("rw_state", dbg_state, ST_IDLE);
        chk("rw_req", dm_req, 1'b0);
        chk("rw_err", err, 1'b0);
        chk("rw_stall", stall, 1'b0);
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        chk("rw_state2", dbg_state, ST_IDLE);
        chk("rw_wb", wb_data, 16'h0080);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
